// File: rtl/globalDefinitions.sv
// Shared definitions: ceiling log2 helper plus the access-mode and clear-FSM state types used
// by the banked RAM.
package globalDefinitions;

  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < n; p = p * 2) begin
      r++;
    end
    return r;
  endfunction

  typedef enum logic {
    SINGLE = 1'b0,
    BLOCK  = 1'b1
  } access_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/inferedAltSync.sv
// One bank of storage: simple dual-port RAM with a registered read that returns the old
// contents on a same-address read/write collision.
module inferedAltSync #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_dual_port_ram.sv
// Banked simple-dual-port RAM with per-lane write enables, write-first bypass, optional output
// register and a post-reset zero-fill sequencer.
module banked_dual_port_ram
  import globalDefinitions::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned WORDS          = 4,
  parameter bit          OUT_REG        = 1'b0,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned EW = (log2(WORDS) < 1) ? 1 : log2(WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         init_done,
  input  logic                         we,
  input  logic                         wblock,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [EW-1:0]                waddrElm,
  input  logic [WORDS-1:0]             wmask,
  input  logic [WORDS*WORD_SIZE-1:0]   wdata,
  input  logic                         re,
  input  logic                         rblock,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  input  logic [EW-1:0]                raddrElm,
  output logic                         rvalid,
  output logic [WORDS*WORD_SIZE-1:0]   q
);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  ready;

  assign ready     = (state_q == READY);
  assign init_done = ready & ~rst;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = READY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (CLEAR_ON_RESET) begin
        state_q <= CLEAR;
      end else begin
        state_q <= READY;
      end
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  access_mode_e                        wmode, rmode;
  logic [WORDS-1:0]                    wr_en;
  logic [WORDS-1:0][WORD_SIZE-1:0]     wr_lane;
  logic [WORDS-1:0]                    bank_we;
  logic [ADDR_WIDTH-1:0]               bank_waddr;
  logic [WORD_SIZE-1:0]                bank_wdata [WORDS];
  logic [WORD_SIZE-1:0]                bank_rdata [WORDS];
  logic                                rd_acc;
  logic [WORDS-1:0]                    byp_d;

  assign wmode      = access_mode_e'(wblock);
  assign rmode      = access_mode_e'(rblock);
  assign rd_acc     = ready & re;
  assign bank_waddr = ready ? waddr : clr_cnt_q;

  // The clear sequencer owns every bank's write port until READY.
  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      wr_lane[i]    = (wmode == BLOCK) ? wdata[i*WORD_SIZE +: WORD_SIZE] : wdata[WORD_SIZE-1:0];
      wr_en[i]      = ready & we & ((wmode == BLOCK) ? wmask[i] : (waddrElm == EW'(i)));
      bank_we[i]    = ~ready | wr_en[i];
      bank_wdata[i] = ready ? wr_lane[i] : '0;
      byp_d[i]      = rd_acc & wr_en[i] & (raddr == waddr);
    end
  end

  for (genvar i = 0; i < WORDS; i++) begin : g_bank
    inferedAltSync #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (WORD_SIZE)
    ) u_bank (
      .clk_i   (clk),
      .we_i    (bank_we[i]),
      .waddr_i (bank_waddr),
      .wdata_i (bank_wdata[i]),
      .raddr_i (raddr),
      .rdata_o (bank_rdata[i])
    );
  end

  logic                            vld1_q;
  access_mode_e                    rmode1_q;
  logic [EW-1:0]                   relm1_q;
  logic [WORDS-1:0]                byp_q;
  logic [WORDS-1:0][WORD_SIZE-1:0] byp_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1_q     <= 1'b0;
      rmode1_q   <= SINGLE;
      relm1_q    <= '0;
      byp_q      <= '0;
      byp_data_q <= '0;
    end else begin
      vld1_q     <= rd_acc;
      rmode1_q   <= rmode;
      relm1_q    <= raddrElm;
      byp_q      <= byp_d;
      byp_data_q <= wr_lane;
    end
  end

  logic [WORDS-1:0][WORD_SIZE-1:0] row_data;
  logic [WORDS-1:0][WORD_SIZE-1:0] q_fmt;

  // Bypassed lanes take the data written in the read's own cycle; the array returned old data.
  always_comb begin
    q_fmt = '0;
    for (int i = 0; i < WORDS; i++) begin
      row_data[i] = byp_q[i] ? byp_data_q[i] : bank_rdata[i];
    end
    if (rmode1_q == BLOCK) begin
      q_fmt = row_data;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (relm1_q == EW'(i)) begin
          q_fmt[0] = row_data[i];
        end
      end
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic                         vld2_q;
    logic [WORDS*WORD_SIZE-1:0]   q_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld2_q <= 1'b0;
        q_q    <= '0;
      end else begin
        vld2_q <= vld1_q;
        if (vld1_q) begin
          q_q <= q_fmt;
        end
      end
    end

    assign rvalid = vld2_q;
    assign q      = q_q;
  end else begin : g_out_comb
    assign rvalid = vld1_q;
    assign q      = vld1_q ? q_fmt : '0;
  end

endmodule
